mux_scan_sequencer: RTL and testbench

- Control stage wrapped around the team's combinational 8:1 mux.
- Accepts an 8-bit word over a valid/ready handshake and holds it on the mux data inputs.
- Steps the 3-bit mux select through all channels, holding each for a set number of cycles, and samples the mux output at the end of each step.
- Emits the sampled bits as a serial stream with a per-bit valid, then signals end of frame.

---
 rtl/mux_scan_pkg.sv | 11 +
 rtl/mux_scan_step_timer.sv | 32 +++
 rtl/mux_scan_sequencer.sv | 130 +++++++++++++
 tb/tb_mux_scan_sequencer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/mux_scan_pkg.sv
// Shared constants for the mux scan sequencer: channel count, select width, FSM encoding.
// The PAR encoding is reserved even when MUX_SCAN_PARITY_EN is undefined.
package mux_scan_pkg;
  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_PAR  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;
endpackage

// File: rtl/mux_scan_step_timer.sv
// Hold-cycle counter: step_o pulses on the last of HOLD cycles while enabled; no backpressure.
// Counter wraps to 0 after each step and is cleared by clr_i or reset.
module mux_scan_step_timer #(
  parameter int HOLD = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic step_o
);
  localparam int CNT_W = $clog2(HOLD + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(HOLD - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign step_o = en_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = step_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/mux_scan_sequencer.sv
// Scans a captured word through an external 8:1 mux and serialises the samples; frame = 8*HOLD+2 cycles,
// in_ready only in IDLE (upstream holds the word). MUX_SCAN_PARITY_EN appends an even-parity ninth bit.
module mux_scan_sequencer
  import mux_scan_pkg::*;
#(
  parameter int HOLD = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [NUM_CH-1:0] in_data,
  output logic [NUM_CH-1:0] mux_i,
  output logic [SEL_W-1:0]  mux_sel,
  input  logic              mux_y,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              frame_done,
  output logic              busy
);
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_CH - 1);

  logic [1:0]        state_q, state_d;
  logic [NUM_CH-1:0] mux_i_q, mux_i_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              ser_q, ser_d;
  logic              ser_vld_q, ser_vld_d;
  logic              done_q, done_d;
  logic              accept;
  logic              step;
`ifdef MUX_SCAN_PARITY_EN
  logic              par_q, par_d;
`endif

  assign accept = in_valid && (state_q == ST_IDLE);

  mux_scan_step_timer #(.HOLD(HOLD)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (accept),
    .en_i   (state_q == ST_SCAN),
    .step_o (step)
  );

  always_comb begin
    state_d   = state_q;
    mux_i_d   = mux_i_q;
    sel_d     = sel_q;
    ser_d     = ser_q;
    ser_vld_d = 1'b0;
    done_d    = 1'b0;
`ifdef MUX_SCAN_PARITY_EN
    par_d     = par_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          mux_i_d = in_data;
          sel_d   = '0;
          state_d = ST_SCAN;
`ifdef MUX_SCAN_PARITY_EN
          par_d   = 1'b0;
`endif
        end
      end
      ST_SCAN: begin
        if (step) begin
          ser_d     = mux_y;
          ser_vld_d = 1'b1;
`ifdef MUX_SCAN_PARITY_EN
          par_d     = par_q ^ mux_y;
`endif
          // Select stops at the last channel; it is never wrapped inside a frame.
          if (sel_q != LAST_SEL) begin
            sel_d = sel_q + 1'b1;
          end else begin
`ifdef MUX_SCAN_PARITY_EN
            state_d = ST_PAR;
`else
            state_d = ST_DONE;
            done_d  = 1'b1;
`endif
          end
        end
      end
`ifdef MUX_SCAN_PARITY_EN
      ST_PAR: begin
        ser_d     = par_q;
        ser_vld_d = 1'b1;
        state_d   = ST_DONE;
        done_d    = 1'b1;
      end
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      mux_i_q   <= '0;
      sel_q     <= '0;
      ser_q     <= 1'b0;
      ser_vld_q <= 1'b0;
      done_q    <= 1'b0;
`ifdef MUX_SCAN_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      mux_i_q   <= mux_i_d;
      sel_q     <= sel_d;
      ser_q     <= ser_d;
      ser_vld_q <= ser_vld_d;
      done_q    <= done_d;
`ifdef MUX_SCAN_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  assign in_ready   = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign mux_i      = mux_i_q;
  assign mux_sel    = sel_q;
  assign ser_out    = ser_q;
  assign ser_valid  = ser_vld_q;
  assign frame_done = done_q;
endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed bench for mux_scan_sequencer with HOLD=1 and HOLD=3 instances and a behavioural 8:1 mux.
// Handles both builds of MUX_SCAN_PARITY_EN.
module tb_mux_scan_sequencer;
`ifdef MUX_SCAN_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       v1, rdy1, y1, so1, sv1, fd1, busy1;
  logic [7:0] d1, mi1;
  logic [2:0] sel1;
  logic       v3, rdy3, y3, so3, sv3, fd3, busy3;
  logic [7:0] d3, mi3;
  logic [2:0] sel3;

  assign y1 = mi1[sel1];
  assign y3 = mi3[sel3];

  mux_scan_sequencer #(.HOLD(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(rdy1), .in_data(d1),
    .mux_i(mi1), .mux_sel(sel1), .mux_y(y1), .ser_out(so1), .ser_valid(sv1),
    .frame_done(fd1), .busy(busy1)
  );

  mux_scan_sequencer #(.HOLD(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(v3), .in_ready(rdy3), .in_data(d3),
    .mux_i(mi3), .mux_sel(sel3), .mux_y(y3), .ser_out(so3), .ser_valid(sv3),
    .frame_done(fd3), .busy(busy3)
  );

  int vec  = 0;
  int errs = 0;

  // {valid, bit} expected at cycle c after acceptance at cycle 0.
  function automatic logic [1:0] exp_out(input logic [7:0] w, input int h, input int c);
    logic [1:0] r;
    r = 2'b00;
    for (int k = 0; k < 8; k++) if (c == 1 + (k + 1) * h) r = {1'b1, w[k]};
    if (PAR == 1 && c == 2 + 8 * h) r = {1'b1, ^w};
    return r;
  endfunction

  function automatic logic [2:0] exp_sel(input int h, input int c);
    int k;
    k = (c - 1) / h;
    if (k > 7) k = 7;
    return 3'(k);
  endfunction

  function automatic int done_cyc(input int h);
    return 1 + 8 * h + PAR;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; v1 = 1'b0; d1 = 8'h00; v3 = 1'b0; d3 = 8'h00;
    repeat (2) @(negedge clk);
    vec++; if ({mi1, sel1, so1, sv1, fd1, busy1, rdy1} !== {8'h00, 3'd0, 4'b0000, 1'b1}) begin
      errs++; $display("FAIL reset_h1 got=%h exp=%h", {mi1, sel1, so1, sv1, fd1, busy1, rdy1}, {8'h00, 3'd0, 4'b0000, 1'b1}); end
    vec++; if ({mi3, sel3, so3, sv3, fd3, busy3, rdy3} !== {8'h00, 3'd0, 4'b0000, 1'b1}) begin
      errs++; $display("FAIL reset_h3 got=%h exp=%h", {mi3, sel3, so3, sv3, fd3, busy3, rdy3}, {8'h00, 3'd0, 4'b0000, 1'b1}); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [1:0] e;
    int dc;
    dc = done_cyc(1);
    @(negedge clk);
    vec++; if (rdy1 !== 1'b1) begin errs++; $display("FAIL basic_ready0 got=%b exp=1", rdy1); end
    d1 = 8'hA5; v1 = 1'b1;
    for (int c = 1; c <= dc + 1; c++) begin
      @(negedge clk);
      if (c == 1) v1 = 1'b0;
      e = exp_out(8'hA5, 1, c);
      vec++; if (sv1 !== e[1]) begin errs++; $display("FAIL basic_valid c=%0d got=%b exp=%b", c, sv1, e[1]); end
      if (e[1]) begin
        vec++; if (so1 !== e[0]) begin errs++; $display("FAIL basic_bit c=%0d got=%b exp=%b", c, so1, e[0]); end
      end
      vec++; if (fd1 !== (c == dc)) begin errs++; $display("FAIL basic_done c=%0d got=%b exp=%b", c, fd1, (c == dc)); end
      vec++; if (rdy1 !== (c == dc + 1)) begin errs++; $display("FAIL basic_ready c=%0d got=%b exp=%b", c, rdy1, (c == dc + 1)); end
      vec++; if (sel1 !== exp_sel(1, c)) begin errs++; $display("FAIL basic_sel c=%0d got=%0d exp=%0d", c, sel1, exp_sel(1, c)); end
      vec++; if (mi1 !== 8'hA5) begin errs++; $display("FAIL basic_mux_i c=%0d got=%h exp=a5", c, mi1); end
    end
  endtask

  task automatic test_hold_stretch();
    logic [1:0] e;
    int dc;
    dc = done_cyc(3);
    @(negedge clk);
    d3 = 8'h81; v3 = 1'b1;
    for (int c = 1; c <= dc + 1; c++) begin
      @(negedge clk);
      if (c == 1) v3 = 1'b0;
      e = exp_out(8'h81, 3, c);
      vec++; if (sv3 !== e[1]) begin errs++; $display("FAIL hold_valid c=%0d got=%b exp=%b", c, sv3, e[1]); end
      if (e[1]) begin
        vec++; if (so3 !== e[0]) begin errs++; $display("FAIL hold_bit c=%0d got=%b exp=%b", c, so3, e[0]); end
      end
      vec++; if (fd3 !== (c == dc)) begin errs++; $display("FAIL hold_done c=%0d got=%b exp=%b", c, fd3, (c == dc)); end
      vec++; if (rdy3 !== (c == dc + 1)) begin errs++; $display("FAIL hold_ready c=%0d got=%b exp=%b", c, rdy3, (c == dc + 1)); end
      vec++; if (sel3 !== exp_sel(3, c)) begin errs++; $display("FAIL hold_sel c=%0d got=%0d exp=%0d", c, sel3, exp_sel(3, c)); end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] e;
    int dc, npulse;
    dc = done_cyc(1);
    @(negedge clk);
    d1 = 8'hFF; v1 = 1'b1;
    for (int c = 1; c <= dc; c++) begin
      @(negedge clk);
      if (c == 1) d1 = 8'h00;
      e = exp_out(8'hFF, 1, c);
      vec++; if (mi1 !== 8'hFF) begin errs++; $display("FAIL b2b_hold_mux_i c=%0d got=%h exp=ff", c, mi1); end
      vec++; if (rdy1 !== 1'b0 || busy1 !== 1'b1) begin errs++; $display("FAIL b2b_busy c=%0d got=%b%b exp=01", c, rdy1, busy1); end
      vec++; if (sv1 !== e[1] || (e[1] && so1 !== e[0])) begin
        errs++; $display("FAIL b2b_first c=%0d got=%b%b exp=%b", c, sv1, so1, e); end
    end
    @(negedge clk);
    vec++; if (rdy1 !== 1'b1) begin errs++; $display("FAIL b2b_idle_ready got=%b exp=1", rdy1); end
    npulse = 0;
    for (int c = 1; c <= dc + 1; c++) begin
      @(negedge clk);
      if (c == 1) v1 = 1'b0;
      e = exp_out(8'h00, 1, c);
      if (sv1 === 1'b1) npulse++;
      vec++; if (mi1 !== 8'h00) begin errs++; $display("FAIL b2b_second_mux_i c=%0d got=%h exp=00", c, mi1); end
      vec++; if (sv1 !== e[1] || (e[1] && so1 !== 1'b0)) begin
        errs++; $display("FAIL b2b_second c=%0d got=%b%b exp=%b", c, sv1, so1, e); end
      vec++; if (fd1 !== (c == dc)) begin errs++; $display("FAIL b2b_done c=%0d got=%b exp=%b", c, fd1, (c == dc)); end
    end
    vec++; if (npulse != 8 + PAR) begin errs++; $display("FAIL b2b_pulses got=%0d exp=%0d", npulse, 8 + PAR); end
  endtask

  task automatic test_reset_mid_frame();
    @(negedge clk);
    d1 = 8'hA5; v1 = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) v1 = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    vec++; if ({mi1, sel1, so1, sv1, fd1, busy1, rdy1} !== {8'h00, 3'd0, 4'b0000, 1'b1}) begin
      errs++; $display("FAIL midrst_state got=%h exp=%h", {mi1, sel1, so1, sv1, fd1, busy1, rdy1}, {8'h00, 3'd0, 4'b0000, 1'b1}); end
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      vec++; if (fd1 !== 1'b0 || sv1 !== 1'b0) begin errs++; $display("FAIL midrst_quiet c=%0d got=%b%b exp=00", c, fd1, sv1); end
    end
  endtask

`ifdef MUX_SCAN_PARITY_EN
  task automatic test_parity(input logic [7:0] w);
    int npulse;
    logic last;
    npulse = 0; last = 1'b0;
    @(negedge clk);
    d1 = w; v1 = 1'b1;
    for (int c = 1; c <= done_cyc(1) + 1; c++) begin
      @(negedge clk);
      if (c == 1) v1 = 1'b0;
      if (sv1 === 1'b1) begin npulse++; last = so1; end
    end
    vec++; if (npulse != 9) begin errs++; $display("FAIL parity_count w=%h got=%0d exp=9", w, npulse); end
    vec++; if (last !== ^w) begin errs++; $display("FAIL parity_bit w=%h got=%b exp=%b", w, last, ^w); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_hold_stretch();
    test_back_to_back();
    test_reset_mid_frame();
`ifdef MUX_SCAN_PARITY_EN
    test_parity(8'h07);
    test_parity(8'hA5);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
